// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t      : fetch FSM states
//   FAULT_*      : fault codes reported to decode
//   NOP_DEFAULT  : addi x0,x0,0, substituted when no real instruction exists
`timescale 1ns/1ps
package if_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
   localparam logic [1:0]  FAULT_BUSERR   = 2'b10;

   localparam logic [31:0] NOP_DEFAULT    = 32'h0000_0013;

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch performance counters. Both are free-running 32-bit counters that wrap.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   fetch_inc    one instruction handed to decode this cycle
//   stall_inc    this cycle was spent waiting for a memory response
//   fetch_cnt    instructions handed to decode
//   stall_cnt    cycles spent waiting on memory
`timescale 1ns/1ps
module if_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_inc,
   input  logic        stall_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= 32'h0;
         stall_cnt <= 32'h0;
      end else begin
         if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage of the multi-cycle RV32I core.
// Holds the architectural PC, fetches one instruction per PC over a
// req/gnt/rvalid port and presents it to decode with valid/ready. The PC is
// replaced by nextpc only when decode accepts the current instruction.
//
// Build option: IF_FETCH_PERF_CNT_EN adds fetch/stall counters (if_perf_cnt);
// without it fetch_cnt/stall_cnt read as zero.
//
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   fetch_en                            permit new memory requests
//   nextpc, pc                          next-PC generator interface
//   imem_req/addr/gnt/rvalid/rdata/err  instruction memory port
//   instr_valid/ready, instr, fault     decode interface
//   fetch_cnt, stall_cnt                performance counters
//
// state  | meaning
// S_REQ  | issue request for pc_q (or flag a misaligned PC); parked if !fetch_en
// S_WAIT | request granted, waiting for rvalid
// S_HOLD | instr/fault presented to decode until instr_ready
`timescale 1ns/1ps
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic [31:0] nextpc,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [1:0]  fault,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [1:0]  fault_q, fault_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

   // rvalid outside S_WAIT (stale response after reset, or same-cycle with
   // gnt) is deliberately ignored.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      fault_d     = fault_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         S_REQ: begin
            if (fetch_en) begin
               if (is_aligned(pc_q)) begin
                  imem_req = 1'b1;
                  if (imem_gnt) state_d = S_WAIT;
               end else begin
                  instr_d = NOP_INSTR;
                  fault_d = FAULT_MISALIGN;
                  state_d = S_HOLD;
               end
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_HOLD;
               if (imem_err) begin
                  instr_d = NOP_INSTR;
                  fault_d = FAULT_BUSERR;
               end else begin
                  instr_d = imem_rdata;
                  fault_d = FAULT_NONE;
               end
            end
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               pc_d    = nextpc;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   assign pc        = pc_q;
   assign imem_addr = {pc_q[31:2], 2'b00};
   assign instr     = instr_q;
   assign fault     = fault_q;

`ifdef IF_FETCH_PERF_CNT_EN
   logic handshake;
   logic in_wait;

   assign handshake = (state_q == S_HOLD) && instr_ready;
   assign in_wait   = (state_q == S_WAIT);

   if_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_inc (handshake),
      .stall_inc (in_wait),
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
   );
`else
   assign fetch_cnt = 32'h0;
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by a randomized run
// against a transaction-level model (PC sequence, memory responses, counters).
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en;
   logic [31:0] nextpc;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [1:0]  fault;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   int n_chk = 0;
   int n_err = 0;

   if_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .nextpc      (nextpc),
      .pc          (pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .fault       (fault),
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr_in();
      fetch_en    = 1'b0;
      nextpc      = 32'h0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      imem_err    = 1'b0;
      instr_ready = 1'b0;
   endtask

   // Returns at the negedge right after rst_n is released, inputs not yet driven.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clr_in();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Zero-wait fetch from the first S_REQ cycle through the handshake.
   // Starts at an undriven negedge; returns at the next undriven negedge.
   task automatic fetch_zero(input logic [31:0] addr, input logic [31:0] rd,
                             input logic er, input logic [31:0] np,
                             input logic [31:0] ei, input logic [1:0] ef);
      fetch_en = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; instr_ready = 1'b0;
      #1;
      chk("fz_pc", pc, addr);
      chk("fz_req", 32'(imem_req), 32'd1);
      chk("fz_addr", imem_addr, addr);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = rd; imem_err = er;
      #1;
      chk("fz_wait_req", 32'(imem_req), 32'd0);
      chk("fz_wait_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; imem_err = 1'b0; instr_ready = 1'b1; nextpc = np;
      #1;
      chk("fz_valid", 32'(instr_valid), 32'd1);
      chk("fz_instr", instr, ei);
      chk("fz_fault", 32'(fault), 32'(ef));
      @(negedge clk);
      instr_ready = 1'b0;
   endtask

   // random-phase model state
   logic [31:0] pc_m, exp_i, ei, tmp;
   logic [1:0]  exp_f, ef;
   logic        pend, resp_done, in_wait;
   int          cnt, idle;
   logic [31:0] fcnt_m, scnt_m;

   initial begin
      clr_in();

      // T1: reset state and zero-wait fetch
      do_reset();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_fcnt", fetch_cnt, 32'd0);
      chk("rst_scnt", stall_cnt, 32'd0);
      fetch_zero(32'h0, 32'h0050_0093, 1'b0, 32'h4, 32'h0050_0093, 2'b00);
      fetch_en = 1'b1;
      #1;
      chk("t1_pc", pc, 32'h4);
      chk("t1_valid_drop", 32'(instr_valid), 32'd0);
      chk("t1_req_next", imem_addr, 32'h4);
      chk("t1_fcnt", fetch_cnt, PERF ? 32'd1 : 32'd0);
      chk("t1_scnt", stall_cnt, PERF ? 32'd1 : 32'd0);

      // T2: 4-cycle response delay, decode stalls 5 cycles
      do_reset();
      fetch_en = 1'b1; imem_gnt = 1'b1; nextpc = 32'h8;
      #1;
      chk("t2_req", 32'(imem_req), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         imem_gnt = 1'b0;
         imem_rvalid = (i == 4);
         imem_rdata = (i == 4) ? 32'h00A0_0113 : 32'hBAD0_0000;
         #1;
         chk("t2_wait_valid", 32'(instr_valid), 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         imem_rvalid = 1'b0; instr_ready = 1'b0; nextpc = 32'h8 + 32'(i);
         #1;
         chk("t2_hold_valid", 32'(instr_valid), 32'd1);
         chk("t2_hold_instr", instr, 32'h00A0_0113);
         chk("t2_hold_fault", 32'(fault), 32'd0);
         chk("t2_hold_pc", pc, 32'h0);
      end
      @(negedge clk);
      instr_ready = 1'b1; nextpc = 32'h8;
      #1;
      chk("t2_stall", stall_cnt, PERF ? 32'd4 : 32'd0);
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      chk("t2_pc", pc, 32'h8);

      // T3: misaligned nextpc
      do_reset();
      fetch_zero(32'h0, 32'h0050_0093, 1'b0, 32'h102, 32'h0050_0093, 2'b00);
      fetch_en = 1'b1; imem_gnt = 1'b1;
      #1;
      chk("t3_pc", pc, 32'h102);
      chk("t3_noreq", 32'(imem_req), 32'd0);
      chk("t3_valid0", 32'(instr_valid), 32'd0);
      @(negedge clk);
      imem_gnt = 1'b0; instr_ready = 1'b1; nextpc = 32'h10;
      #1;
      chk("t3_valid", 32'(instr_valid), 32'd1);
      chk("t3_instr", instr, NOP);
      chk("t3_fault", 32'(fault), 32'd1);
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      chk("t3_pc_after", pc, 32'h10);

      // T4: bus error at address 8
      do_reset();
      fetch_zero(32'h0, 32'h0050_0093, 1'b0, 32'h8, 32'h0050_0093, 2'b00);
      fetch_zero(32'h8, 32'hDEAD_BEEF, 1'b1, 32'h20, NOP, 2'b10);
      #1;
      chk("t4_pc", pc, 32'h20);

      // T5: reset during S_WAIT, stale rvalid after release
      do_reset();
      fetch_en = 1'b1; imem_gnt = 1'b1;
      #1;
      @(negedge clk);
      imem_gnt = 1'b0;
      #1;
      chk("t5_in_wait", 32'(imem_req), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; fetch_en = 1'b1;
      #1;
      chk("t5_pc", pc, 32'h0);
      chk("t5_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      #1;
      chk("t5_stale_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0;
      #1;
      chk("t5_stale_valid2", 32'(instr_valid), 32'd0);
      chk("t5_req2", 32'(imem_req), 32'd1);
      @(negedge clk);
      fetch_zero(32'h0, 32'h0010_0093, 1'b0, 32'h4, 32'h0010_0093, 2'b00);

      // T6: fetch_en low after reset
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i != 0) @(negedge clk);
         fetch_en = 1'b0; imem_gnt = 1'b1;
         #1;
         chk("t6_req", 32'(imem_req), 32'd0);
         chk("t6_valid", 32'(instr_valid), 32'd0);
      end
      @(negedge clk);
      fetch_en = 1'b1;
      #1;
      chk("t6_req_on", 32'(imem_req), 32'd1);
      chk("t6_addr", imem_addr, 32'h0);

      // Randomized run against the transaction model
      do_reset();
      pc_m = 32'h0; pend = 1'b0; resp_done = 1'b0; cnt = 0; idle = 0;
      fcnt_m = 32'h0; scnt_m = 32'h0; exp_i = NOP; exp_f = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         in_wait = pend;
         fetch_en = ($urandom_range(0, 9) != 0);
         instr_ready = $urandom_range(0, 1) == 1;
         tmp = $urandom;
         case ($urandom_range(0, 7))
            0:       nextpc = {tmp[31:2], 2'b01 | tmp[1:0]};
            1:       nextpc = 32'hFFFF_FFFC;
            default: nextpc = {16'h0, tmp[15:2], 2'b00};
         endcase
         imem_gnt = $urandom_range(0, 1) == 1;
         imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_err = ($urandom_range(0, 3) == 0);
               pend = 1'b0;
               resp_done = 1'b1;
               exp_i = imem_err ? NOP : imem_rdata;
               exp_f = imem_err ? 2'b10 : 2'b00;
            end
         end
         #1;
         chk("r_pc", pc, pc_m);
         chk("r_fcnt", fetch_cnt, PERF ? fcnt_m : 32'd0);
         chk("r_scnt", stall_cnt, PERF ? scnt_m : 32'd0);
         if (imem_req) begin
            chk("r_req_en", 32'(fetch_en), 32'd1);
            chk("r_req_align", 32'(pc_m[1:0]), 32'd0);
            chk("r_req_addr", imem_addr, {pc_m[31:2], 2'b00});
            chk("r_req_busy", 32'(in_wait), 32'd0);
         end
         if (instr_valid) begin
            if (pc_m[1:0] != 2'b00) begin
               ei = NOP; ef = 2'b01;
            end else begin
               chk("r_resp_seen", 32'(resp_done), 32'd1);
               ei = exp_i; ef = exp_f;
            end
            chk("r_instr", instr, ei);
            chk("r_fault", 32'(fault), 32'(ef));
         end
         if (in_wait) scnt_m = scnt_m + 32'd1;
         if (imem_req && imem_gnt) begin
            pend = 1'b1;
            cnt = $urandom_range(1, 4);
         end
         if (instr_valid && instr_ready) begin
            pc_m = nextpc;
            fcnt_m = fcnt_m + 32'd1;
            resp_done = 1'b0;
            idle = 0;
         end else begin
            idle++;
         end
         if (idle > 100) begin
            chk("r_liveness", 32'(idle), 32'd0);
            idle = 0;
         end
      end
      chk("r_min_fetches", 32'(fcnt_m > 32'd200), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch stage of the multi-cycle RV32I core. Sits directly downstream of the next-PC generator.
- Holds the architectural PC register and drives it to the next-PC generator and decode.
- Fetches one instruction per PC over a req/gnt/rvalid instruction-memory port and presents it to decode with valid/ready.
- Loads the generator's nextpc only when decode accepts the current instruction.

Parameters:
RESET_PC  32'h0000_0000  PC value after reset
NOP_INSTR  32'h0000_0013  instruction substituted on a fault (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allows new memory requests; 0 parks the block in S_REQ
nextpc  in  32  next PC from the next-PC generator
pc  out  32  current PC (pc_q), to the next-PC generator and decode
imem_req  out  1  memory request valid
imem_addr  out  32  request address, {pc_q[31:2],2'b00}
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
imem_err  in  1  bus error, qualified by imem_rvalid
instr_valid  out  1  instr/fault valid to decode
instr_ready  in  1  decode accepts
instr  out  32  fetched instruction
fault  out  2  00 none, 01 misaligned PC, 10 bus error
fetch_cnt  out  32  perf: instructions handed to decode
stall_cnt  out  32  perf: cycles spent in S_WAIT

Behaviour:
- Reset (async, rst_n=0):
  - state=S_REQ, pc_q=RESET_PC, instr_q=NOP_INSTR, fault_q=00.
  - imem_req=0, instr_valid=0, counters=0.
  - Reset mid-transaction abandons it; the block never stalls on a lost response.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ, normal request:
  - imem_req = fetch_en & (pc_q[1:0]==0).
  - Stay in S_REQ until imem_gnt; on imem_req & imem_gnt go to S_WAIT.
- S_REQ, misaligned PC:
  - If fetch_en & pc_q[1:0]!=0: no request. Next cycle enter S_HOLD with instr_q=NOP_INSTR, fault_q=01.
- S_REQ, stray response: imem_rvalid here (stale response after reset) is ignored.
- S_WAIT:
  - imem_req=0. On imem_rvalid: instr_q<=imem_rdata, fault_q<=imem_err?10:00, go to S_HOLD.
  - On a bus error, instr_q<=NOP_INSTR instead of imem_rdata.
  - rvalid arrives no earlier than the cycle after gnt; a same-cycle rvalid in S_REQ is a protocol error and is ignored.
- S_HOLD:
  - instr_valid=1; instr and fault stay stable while instr_ready=0.
  - On instr_ready: pc_q<=nextpc (sampled that cycle), instr_valid drops next cycle, go to S_REQ.
- Latency with zero-wait memory (gnt in the first S_REQ cycle, rvalid in the next): S_REQ→S_WAIT→S_HOLD, instr_valid in the 3rd cycle after entering S_REQ.
- Steady-state throughput: one instruction per 3 cycles with instr_ready held high.
- fetch_en deasserted in S_WAIT/S_HOLD: the current transaction completes; the block then parks in S_REQ.
- pc always equals pc_q and changes only on an S_HOLD handshake.
- No wrap protection: nextpc=32'hFFFF_FFFC → 0 is passed through unmodified.

Optional Feature:
IF_FETCH_PERF_CNT_EN
- Defined: fetch_cnt increments on each S_HOLD handshake; stall_cnt increments each cycle in S_WAIT.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports tie to 32'h0 and the counter logic is absent.

Decomposition:
- Package if_pkg holds:
  - the state enum (S_REQ/S_WAIT/S_HOLD)
  - fault codes FAULT_NONE/FAULT_MISALIGN/FAULT_BUSERR
  - the default NOP encoding
- One sub-module, if_perf_cnt (the two counters), instantiated only under the macro.

Test Plan:
- Reset release, zero-wait memory returning 32'h00500093 at addr 0, ready=1 → imem_addr=0; instr_valid in 3rd cycle with instr=32'h00500093, fault=00; pc then becomes nextpc=4.
- Memory with 4-cycle rvalid delay, ready held 0 for 5 cycles in S_HOLD → instr/fault stable throughout; pc stays put until ready; stall_cnt=4 (macro on).
- nextpc=32'h0000_0102 accepted → no imem_req; instr_valid next cycle with instr=32'h00000013, fault=01.
- imem_err=1 with rvalid at addr 8 → instr=32'h00000013, fault=10; after handshake pc=nextpc.
- rst_n pulsed low while in S_WAIT, stale rvalid 1 cycle after release → pc=RESET_PC; stale data never appears on instr; a new request issues at RESET_PC.
- fetch_en=0 after reset for 10 cycles → imem_req stays 0, instr_valid 0; raise fetch_en → request at RESET_PC the same cycle.
